// File: rtl/pong_pkg.sv
// Shared Pong definitions: paddle FSM states and screen geometry used by the
// paddle, ball and draw-checker logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } paddle_state_t;

  localparam int DEFAULT_V_CNT_WID     = 10;
  localparam int DEFAULT_SCREEN_HEIGHT = 480;
  localparam int DEFAULT_PLAYER_HEIGHT = 64;

endpackage

// File: rtl/btn_synchronizer.sv
// Two-flop synchroniser for a bundle of asynchronous push buttons.
module btn_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btnAsync,
  output logic [WIDTH-1:0] btnSync
);

  logic [WIDTH-1:0] metaStage;

  always_ff @(posedge clk) begin
    if (rst) begin
      metaStage <= '0;
      btnSync   <= '0;
    end else begin
      metaStage <= btnAsync;
      btnSync   <= metaStage;
    end
  end

endmodule

// File: rtl/player_paddle_ctrl.sv
// One player's paddle: per-frame movement with hold-to-accelerate, screen clamping,
// and a delayed per-line isValidY qualifier aligned with the draw pipeline.
module player_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PIPELINE_STAGES = 2,
  parameter int V_CNT_WID       = DEFAULT_V_CNT_WID,
  parameter int SCREEN_HEIGHT   = DEFAULT_SCREEN_HEIGHT,
  parameter int PLAYER_HEIGHT   = DEFAULT_PLAYER_HEIGHT,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_MAX       = 8,
  parameter int ACCEL_FRAMES    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btnUp,
  input  logic                 btnDown,
  input  logic                 frameStart,
  input  logic [V_CNT_WID-1:0] drawY,
  output logic [V_CNT_WID-1:0] playerY,
  output logic                 isValidY
);

  localparam int VW1     = V_CNT_WID + 1;
  localparam int CNT_WID = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [V_CNT_WID-1:0] START_Y  = V_CNT_WID'((SCREEN_HEIGHT - PLAYER_HEIGHT) / 2);
  localparam logic [V_CNT_WID-1:0] MAX_Y    = V_CNT_WID'(SCREEN_HEIGHT - PLAYER_HEIGHT);
  localparam logic [V_CNT_WID-1:0] SPD_MIN  = V_CNT_WID'(SPEED_MIN);
  localparam logic [V_CNT_WID-1:0] SPD_MAX  = V_CNT_WID'(SPEED_MAX);
  localparam logic [CNT_WID-1:0]   CNT_LAST = CNT_WID'(ACCEL_FRAMES - 1);

  logic [1:0] btnSync;
  logic       upOnly;
  logic       downOnly;

  btn_synchronizer #(
    .WIDTH(2)
  ) uBtnSync (
    .clk      (clk),
    .rst      (rst),
    .btnAsync ({btnUp, btnDown}),
    .btnSync  (btnSync)
  );

  assign upOnly   = btnSync[1] & ~btnSync[0];
  assign downOnly = btnSync[0] & ~btnSync[1];

  paddle_state_t           state;
  paddle_state_t           dirReq;
  paddle_state_t           nextState;
  logic [V_CNT_WID-1:0]    speed;
  logic [V_CNT_WID-1:0]    nextSpeed;
  logic [V_CNT_WID-1:0]    nextY;
  logic [CNT_WID-1:0]      accelCnt;
  logic [CNT_WID-1:0]      nextCnt;
  logic [CNT_WID-1:0]      cntInc;
  logic [V_CNT_WID:0]      downSum;

  // The move this frame uses the speed after this frame's acceleration update.
  always_comb begin
    dirReq    = upOnly ? UP : (downOnly ? DOWN : IDLE);
    nextState = state;
    nextSpeed = speed;
    nextCnt   = accelCnt;
    cntInc    = accelCnt + CNT_WID'(1);
    if (dirReq == IDLE) begin
      nextState = IDLE;
      nextSpeed = SPD_MIN;
      nextCnt   = '0;
    end else if (state != dirReq) begin
      nextState = dirReq;
      nextSpeed = SPD_MIN;
      nextCnt   = '0;
    end else if (cntInc == CNT_LAST) begin
      nextCnt   = '0;
      nextSpeed = (speed >= SPD_MAX) ? SPD_MAX : speed + V_CNT_WID'(1);
    end else begin
      nextCnt   = cntInc;
    end

    downSum = {1'b0, playerY} + {1'b0, nextSpeed};
    nextY   = playerY;
    case (nextState)
      UP:      nextY = (playerY < nextSpeed) ? '0 : playerY - nextSpeed;
      DOWN:    nextY = (downSum > {1'b0, MAX_Y}) ? MAX_Y : downSum[V_CNT_WID-1:0];
      default: nextY = playerY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      speed    <= SPD_MIN;
      accelCnt <= '0;
      playerY  <= START_Y;
    end else if (frameStart) begin
      state    <= nextState;
      speed    <= nextSpeed;
      accelCnt <= nextCnt;
      playerY  <= nextY;
    end
  end

  logic [V_CNT_WID:0] paddleEnd;
  logic               rawValid;

  assign paddleEnd = {1'b0, playerY} + VW1'(PLAYER_HEIGHT);
  assign rawValid  = ({1'b0, drawY} >= {1'b0, playerY}) && ({1'b0, drawY} < paddleEnd);

  generate
    if (PIPELINE_STAGES == 0) begin : gNoPipe
      assign isValidY = rawValid;
    end else begin : gPipe
      logic [PIPELINE_STAGES-1:0] validPipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          validPipe <= '0;
        end else begin
          validPipe[0] <= rawValid;
          for (int i = 1; i < PIPELINE_STAGES; i++) begin
            validPipe[i] <= validPipe[i-1];
          end
        end
      end

      assign isValidY = validPipe[PIPELINE_STAGES-1];
    end
  endgenerate

endmodule
